// File: rtl/booth_pkg.sv
// ----------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the radix-4 Booth multiplier:
//   state_t  - controller states (IDLE, CALC, DONE)
//   digit_t  - Booth digit code packed as {neg, one, two}
//   DIG_*    - the five legal Booth digits in that packing
//   clog2    - ceiling log2, used to size the iteration counter
// ----------------------------------------------------------------------------
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit code is {neg, one, two}: magnitude select plus sign.
  typedef logic [2:0] digit_t;

  localparam digit_t DIG_ZERO = 3'b000;
  localparam digit_t DIG_P1   = 3'b010;
  localparam digit_t DIG_P2   = 3'b001;
  localparam digit_t DIG_M1   = 3'b110;
  localparam digit_t DIG_M2   = 3'b101;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// ----------------------------------------------------------------------------
// booth_r4_encoder
// Combinational radix-4 Booth recoder. Maps the 3-bit multiplier window
// {q[2i+1], q[2i], q[2i-1]} to a digit in {0, +1, +2, -1, -2}.
// Ports:
//   window - input  [2:0] multiplier window
//   neg    - output       digit is negative
//   one    - output       digit magnitude is 1
//   two    - output       digit magnitude is 2
// ----------------------------------------------------------------------------
module booth_r4_encoder
  import booth_pkg::*;
(
  input  logic [2:0] window,
  output logic       neg,
  output logic       one,
  output logic       two
);

  digit_t digit;

  always_comb begin
    digit = DIG_ZERO;
    case (window)
      3'b001,
      3'b010:  digit = DIG_P1;
      3'b011:  digit = DIG_P2;
      3'b100:  digit = DIG_M2;
      3'b101,
      3'b110:  digit = DIG_M1;
      default: digit = DIG_ZERO;  // 000 and 111 both encode zero
    endcase
  end

  assign {neg, one, two} = digit;

endmodule

// File: rtl/booth_radix4_mult.sv
// ----------------------------------------------------------------------------
// booth_radix4_mult
// Sequential radix-4 Booth multiplier, two multiplier bits retired per cycle.
// Operands are widened by two bits (sign- or zero-extended by is_signed) so a
// single signed Booth datapath serves both modes.
// Parameters:
//   WIDTH        - operand width, even and >= 4; result is 2*WIDTH bits
// Ports:
//   clk          - input   rising-edge clock
//   rst          - input   asynchronous active-low reset
//   start        - input   launch request, only honoured in IDLE
//   is_signed    - input   1 = two's-complement, 0 = unsigned (sampled w/ start)
//   multiplicand - input   operand A (sampled with start)
//   multiplier   - input   operand B (sampled with start)
//   busy         - output  high in CALC and DONE
//   done         - output  one-cycle pulse, result valid in that cycle
//   result       - output  product, held until the next DONE
// Timing: start sampled at edge k, N = WIDTH/2+1 iterations on edges
// k+1..k+N, result registered and DONE entered at edge k+N+1, back to IDLE
// at edge k+N+2.
// ----------------------------------------------------------------------------
module booth_radix4_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int EW = WIDTH + 2;       // extended operand width
  localparam int N  = EW / 2;          // Booth iterations
  localparam int AW = EW + 2;          // upper accumulator, two guard bits for +/-2A
  localparam int CW = clog2(N + 1);    // counter must reach N
  localparam int RW = 2 * WIDTH;

  localparam logic [CW-1:0] LAST_CNT = CW'(N);

  // The product accumulator is {hi_q, q_q}: the upper half collects the
  // partial sums while the multiplier is shifted out of the lower half.
  // The extended operands already encode the mode, so the mode bit itself
  // does not need to be kept past the launch edge.
  state_t                  state_q, state_d;
  logic signed [EW-1:0]    a_q, a_d;
  logic signed [AW-1:0]    hi_q, hi_d;
  logic        [EW-1:0]    q_q, q_d;
  logic                    qm1_q, qm1_d;
  logic        [CW-1:0]    cnt_q, cnt_d;
  logic        [RW-1:0]    result_q, result_d;

  logic                    dig_neg;
  logic                    dig_one;
  logic                    dig_two;
  logic signed [AW-1:0]    a_wide;
  logic signed [AW-1:0]    mag;
  logic signed [AW-1:0]    addend;
  logic signed [AW-1:0]    sum;

  booth_r4_encoder u_enc (
    .window ({q_q[1], q_q[0], qm1_q}),
    .neg    (dig_neg),
    .one    (dig_one),
    .two    (dig_two)
  );

  // Partial-product adder: hi + digit * A
  always_comb begin
    a_wide = {{2{a_q[EW-1]}}, a_q};
    mag    = '0;
    if (dig_two) begin
      mag = a_wide <<< 1;
    end else if (dig_one) begin
      mag = a_wide;
    end
    addend = dig_neg ? -mag : mag;
    sum    = hi_q + addend;
  end

  // Next-state and register updates
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    hi_d     = hi_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = {{2{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
          q_d     = {{2{is_signed & multiplier[WIDTH-1]}}, multiplier};
          hi_d    = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        if (cnt_q == LAST_CNT) begin
          // All digits consumed; low 2*WIDTH bits are exact in both modes.
          result_d = RW'({hi_q, q_q});
          state_d  = DONE;
        end else begin
          // Arithmetic shift of {sum, q} right by two.
          hi_d  = sum >>> 2;
          q_d   = {sum[1:0], q_q[EW-1:2]};
          qm1_d = q_q[1];
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      hi_q     <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == CALC) || (state_q == DONE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// ----------------------------------------------------------------------------
// tb_booth_radix4_mult
// Bench for booth_radix4_mult with a WIDTH=16 and a WIDTH=8 instance.
// Expected products come from plain integer multiplication of the operands
// interpreted per the mode, truncated to 2*WIDTH bits.
// ----------------------------------------------------------------------------
module tb_booth_radix4_mult;

  logic        clk = 1'b0;
  logic        rst;

  logic        start16, sg16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [31:0] res16;

  logic        start8, sg8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] res8;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  booth_radix4_mult #(.WIDTH(16)) dut16 (
    .clk          (clk),
    .rst          (rst),
    .start        (start16),
    .is_signed    (sg16),
    .multiplicand (a16),
    .multiplier   (b16),
    .busy         (busy16),
    .done         (done16),
    .result       (res16)
  );

  booth_radix4_mult #(.WIDTH(8)) dut8 (
    .clk          (clk),
    .rst          (rst),
    .start        (start8),
    .is_signed    (sg8),
    .multiplicand (a8),
    .multiplier   (b8),
    .busy         (busy8),
    .done         (done8),
    .result       (res8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: interpret operands per mode, multiply, keep 2*w bits.
  function automatic logic [31:0] model(input int w, input logic [15:0] a,
                                        input logic [15:0] b, input logic s);
    longint sa, sb, p;
    logic [63:0] mask;
    if (w == 16) begin
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
    end else begin
      sa = s ? longint'($signed(a[7:0])) : longint'(a[7:0]);
      sb = s ? longint'($signed(b[7:0])) : longint'(b[7:0]);
    end
    p    = sa * sb;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 32'(64'(p) & mask);
  endfunction

  // One complete operation on the selected instance with full checking.
  task automatic op(input int w, input logic [15:0] a, input logic [15:0] b,
                    input logic s, input string tag, output logic [31:0] got);
    int          cyc;
    bit          seen;
    bit          busy_ok;
    logic [31:0] exp;
    exp = model(w, a, b, s);
    @(negedge clk);
    if (w == 16) begin
      a16 = a; b16 = b; sg16 = s; start16 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; sg8 = s; start8 = 1'b1;
    end
    @(posedge clk);
    #1;
    // Scramble inputs after the sampling edge; they must not matter.
    start16 = 1'b0; start8 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); sg16 = ~sg16;
    a8  = 8'($urandom);  b8  = 8'($urandom);  sg8  = ~sg8;
    cyc = 0; seen = 0; busy_ok = 1;
    while (!seen && cyc < 40) begin
      if (((w == 16) ? busy16 : busy8) !== 1'b1) busy_ok = 0;
      @(posedge clk);
      #1;
      cyc++;
      if (((w == 16) ? done16 : done8) === 1'b1) seen = 1;
    end
    if (((w == 16) ? busy16 : busy8) !== 1'b1) busy_ok = 0;
    got = (w == 16) ? res16 : {16'h0, res8};
    chk({tag, "/done_seen"}, 64'(seen), 64'd1);
    chk({tag, "/latency"}, 64'(cyc), 64'(w / 2 + 2));
    chk({tag, "/busy"}, 64'(busy_ok), 64'd1);
    chk({tag, "/result"}, 64'(got), 64'(exp));
    @(posedge clk);
    #1;
    chk({tag, "/done_pulse"}, 64'((w == 16) ? done16 : done8), 64'd0);
    chk({tag, "/held"}, 64'((w == 16) ? res16 : {16'h0, res8}), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int          dcount;
    logic [31:0] rcap;

    rst = 1'b0;
    start16 = 1'b0; sg16 = 1'b0; a16 = '0; b16 = '0;
    start8  = 1'b0; sg8  = 1'b0; a8  = '0; b8  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/busy16", 64'(busy16), 64'd0);
    chk("reset/done16", 64'(done16), 64'd0);
    chk("reset/res16",  64'(res16),  64'd0);
    chk("reset/busy8",  64'(busy8),  64'd0);
    chk("reset/res8",   64'(res8),   64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed products, WIDTH=16
    op(16, 16'd7, 16'd3, 1'b1, "s7x3", r);
    chk("s7x3/lit", 64'(r), 64'd21);
    op(16, 16'hFFFB, 16'd4, 1'b1, "sm5x4", r);
    chk("sm5x4/lit", 64'(r), 64'hFFFF_FFEC);
    op(16, 16'h8000, 16'h8000, 1'b1, "smin_sq", r);
    chk("smin_sq/lit", 64'(r), 64'h4000_0000);
    op(16, 16'hFFFF, 16'h7FFF, 1'b1, "sm1xmax", r);
    chk("sm1xmax/lit", 64'(r), 64'hFFFF_8001);
    op(16, 16'hFFFF, 16'hFFFF, 1'b0, "u_ones", r);
    chk("u_ones/lit", 64'(r), 64'hFFFE_0001);
    op(16, 16'hFFFF, 16'hFFFF, 1'b1, "s_ones", r);
    chk("s_ones/lit", 64'(r), 64'd1);
    op(16, 16'h0000, 16'hFFFF, 1'b0, "u_zero", r);
    chk("u_zero/lit", 64'(r), 64'd0);

    // Start pulsed while busy must be ignored
    @(negedge clk);
    a16 = 16'd7; b16 = 16'd3; sg16 = 1'b1; start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a16 = 16'd100; b16 = 16'd100; start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    dcount = 0; rcap = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done16 === 1'b1) begin
        dcount++;
        rcap = res16;
      end
    end
    chk("busy_ign/dones", 64'(dcount), 64'd1);
    chk("busy_ign/result", 64'(rcap), 64'd21);

    // Start held high: operations relaunch after each DONE
    @(negedge clk);
    a16 = 16'd3; b16 = 16'd5; sg16 = 1'b0; start16 = 1'b1;
    dcount = 0; rcap = '0;
    for (int i = 0; i < 26; i++) begin
      @(posedge clk);
      #1;
      if (done16 === 1'b1) begin
        dcount++;
        rcap = res16;
      end
    end
    start16 = 1'b0;
    chk("held/dones", 64'(dcount), 64'd2);
    chk("held/result", 64'(rcap), 64'd15);
    repeat (15) @(posedge clk);

    // Reset mid-operation
    @(negedge clk);
    a16 = 16'd15; b16 = 16'd15; sg16 = 1'b1; start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst/busy", 64'(busy16), 64'd0);
    chk("midrst/done", 64'(done16), 64'd0);
    chk("midrst/result", 64'(res16), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst/no_done", 64'(done16), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    op(16, 16'd0, 16'hFFE7, 1'b1, "zero_x_m25", r);
    chk("zero_x_m25/lit", 64'(r), 64'd0);

    // WIDTH=8 instance
    op(8, 16'h0080, 16'h007F, 1'b1, "w8_s", r);
    chk("w8_s/lit", 64'(r), 64'h0000_C080);
    op(8, 16'h00FF, 16'h00FF, 1'b0, "w8_u", r);
    chk("w8_u/lit", 64'(r), 64'd65025);
    op(8, 16'h0080, 16'h0080, 1'b1, "w8_min_sq", r);

    // Randomised operands and modes
    for (int i = 0; i < 16; i++) begin
      op(16, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), "rand16", r);
    end
    for (int i = 0; i < 16; i++) begin
      op(8, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), "rand8", r);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
